// File: rtl/main_fsm.sv
// Multicycle control FSM for an RV32I subset: sequences datapath selects, write enables
// and the memory handshake, counts retired instructions and flags illegal opcodes.
module main_fsm #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_update,
  output logic             branch,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] instr_retired
);

  // Memory handshake: a request (mem_req=1) completes in the cycle mem_ready=1; until then the
  // FSM holds its state and keeps mem_req, mem_write and adr_src stable.
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
  } state_t;

  state_t state;
  state_t state_next;
  logic   retire;

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECR;
          7'b0010011:             state_next = S_EXECI;
          7'b1100011:             state_next = S_BRANCH;
          7'b1101111:             state_next = S_JAL;
          default: begin
            if (ILLEGAL_TRAP) begin
              state_next = S_ILLEGAL;
            end else begin
              state_next = S_FETCH;
              retire     = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_MEMWB, S_ALUWB, S_BRANCH: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_EXECR, S_EXECI: state_next = S_ALUWB;
      S_JAL:            state_next = S_ALUWB;
      S_ILLEGAL:        state_next = S_ILLEGAL;
      default:          state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      instr_retired <= '0;
      trap          <= 1'b0;
    end else begin
      state <= state_next;
      if (retire) instr_retired <= instr_retired + CNT_W'(1);
      if (state_next == S_ILLEGAL) trap <= 1'b1;
    end
  end

  // Moore decode; only the FETCH IR/PC strobes look at mem_ready. Reset masks everything.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_op     = 2'b00;
    end
  end

endmodule
